// File: rtl/encoder4to2_arb_pkg.sv
// Shared constants and FSM state encoding for the 4-to-2 arbitrating encoder.
package encoder4to2_arb_pkg;

  localparam int REQ_W = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/encoder4to2_pick.sv
// Combinational selector: highest set index (mode 0) or first set index at or
// after start, wrapping (mode 1). Also flags whether more than one bit is set.
module encoder4to2_pick
  import encoder4to2_arb_pkg::*;
(
  input  logic [REQ_W-1:0] vec,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             multi,
  output logic             any
);

  logic [IDX_W-1:0] j;
  logic             found;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    idx   = '0;
    j     = '0;
    found = 1'b0;
    if (!mode) begin
      // Ascending scan: the last set bit seen is the highest one.
      for (int i = 0; i < REQ_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < REQ_W; k++) begin
        j = start + IDX_W'(k);
        if (!found && vec[j]) begin
          idx   = j;
          found = 1'b1;
        end
      end
    end
  end

  assign any   = |vec;
  assign multi = ($countones(vec) > 1);

endmodule

// File: rtl/encoder4to2_arb.sv
// Sticky-request 4-to-2 encoder with fixed or rotating priority and a
// VALID/ACK handshake; every output comes straight from a register.
module encoder4to2_arb
  import encoder4to2_arb_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] REQ,
  input  logic             ACK,
  output logic [IDX_W-1:0] Y,
  output logic             VALID,
  output logic             MULTI,
  output logic [REQ_W-1:0] PENDING
);

  state_t           state, state_d;
  logic [IDX_W-1:0] y_d, last, last_d, start;
  logic             multi_d, accept;
  logic [REQ_W-1:0] clr, pending_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_multi, pick_any;

  assign VALID  = (state == GRANT);
  assign accept = VALID & ACK;

  always_comb begin
    clr = '0;
    if (accept) clr[Y] = 1'b1;
  end

  // A new request on the bit being cleared keeps it set.
  assign pending_d = (PENDING & ~clr) | REQ;

  // Rotation resumes after the index being accepted this very edge.
  assign start = accept ? Y + 1'b1 : last + 1'b1;

  encoder4to2_pick u_pick (
    .vec   (pending_d),
    .start (start),
    .mode  (RR),
    .idx   (pick_idx),
    .multi (pick_multi),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state;
    y_d     = Y;
    multi_d = MULTI;
    last_d  = accept ? Y : last;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          y_d     = pick_idx;
          multi_d = pick_multi;
        end
      end
      GRANT: begin
        if (ACK) begin
          if (pick_any) begin
            y_d     = pick_idx;
            multi_d = pick_multi;
          end else begin
            state_d = IDLE;
            multi_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      Y       <= '0;
      MULTI   <= 1'b0;
      PENDING <= '0;
      last    <= '1;
    end else begin
      state   <= state_d;
      Y       <= y_d;
      MULTI   <= multi_d;
      PENDING <= pending_d;
      last    <= last_d;
    end
  end

endmodule

// File: doc/encoder4to2_arb.md
ENCODER4TO2_ARB -- requirements
Module: encoder4to2_arb

Interface
REQ-001 The block SHALL have parameter RR, default 0, selecting fixed priority (0) or rotating priority (1).
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, reset, asynchronous and active-high.
REQ-004 Port REQ SHALL be input, 4 bits, request lines; bit i requests encoded output i.
REQ-005 Port ACK SHALL be input, 1 bit, consumer accepts current Y when high with VALID.
REQ-006 Port Y SHALL be output, 2 bits, registered encoded index of the granted request.
REQ-007 Port VALID SHALL be output, 1 bit, registered; Y is meaningful when high.
REQ-008 Port MULTI SHALL be output, 1 bit, registered; more than one bit was pending when Y was selected.
REQ-009 Port PENDING SHALL be output, 4 bits, registered sticky request vector.

Function
REQ-010 Each rising edge SHALL compute PENDING_next = (PENDING & ~clr) | REQ, where clr is one-hot of Y when VALID & ACK, else 0.
REQ-011 A REQ bit and its clear in the same cycle SHALL leave that bit set (set wins).
REQ-012 The FSM SHALL have two states, IDLE and GRANT; VALID SHALL equal (state == GRANT).
REQ-013 IDLE -> GRANT SHALL occur at the edge where PENDING_next is nonzero; Y and MULTI load from PENDING_next at that edge.
REQ-014 Latency from a REQ bit sampled high in IDLE to VALID high SHALL be exactly one cycle.
REQ-015 In GRANT with ACK low, Y, MULTI and state SHALL hold unchanged; new requests only update PENDING.
REQ-016 In GRANT with ACK high: if PENDING_next nonzero, stay GRANT and load a new Y/MULTI from PENDING_next; else go to IDLE with Y held and MULTI cleared.
REQ-017 Back-to-back grants SHALL sustain one accepted index per cycle while ACK stays high and requests remain.
REQ-018 RR=0: selection SHALL be highest set index (3 beats 2 beats 1 beats 0).
REQ-019 RR=1: selection SHALL be first set index scanning ascending from (last+1) mod 4, wrapping 3 -> 0; last updates to Y on each accepted grant only.
REQ-020 MULTI SHALL be 1 when popcount of the vector Y was selected from is at least 2, else 0.
REQ-021 ACK while VALID low SHALL be ignored.
REQ-022 REQ is treated as synchronous to clk; no internal synchronizer.

Reset
REQ-023 While rst is high: state=IDLE, Y=2'b00, VALID=0, MULTI=0, PENDING=4'b0000, last=2'b11; asynchronous assert.
REQ-024 Reset asserted mid-grant SHALL discard all pending requests; first edge after rst deasserts samples REQ normally.

Structure
REQ-025 A shared package SHALL hold the state encoding constants (IDLE, GRANT), the request width 4 and index width 2.
REQ-026 Selection logic SHALL be one combinational sub-module, encoder4to2_pick (inputs vector, start index, mode; outputs index, multi, any).
REQ-027 All outputs SHALL be driven directly from registers.

Verification
REQ-028 Fixed: RR=0, REQ=4'b0100 one cycle, ACK=1 -> next cycle VALID=1 Y=2 MULTI=0; following cycle VALID=0, PENDING=0.
REQ-029 Priority/backpressure: RR=0, REQ=4'b1011 one cycle, ACK=0 three cycles then 1 -> Y=3 MULTI=1 held three cycles, then Y=1, Y=0 (MULTI=0), then IDLE.
REQ-030 Rotation: RR=1, REQ=4'b1111 held, ACK=1 -> Y sequence 0,1,2,3,0 on consecutive cycles, VALID constant 1.
REQ-031 Set-wins: RR=0, Y=2 VALID=1, ACK=1 and REQ=4'b0100 same cycle -> PENDING[2] stays 1, next Y=2.
REQ-032 Reset mid-op: PENDING=4'b0110 VALID=1, pulse rst -> VALID=0 Y=0 MULTI=0 PENDING=0 immediately, no grant until new REQ.
REQ-033 Stray ACK: IDLE, ACK=1 REQ=0 for 5 cycles -> all outputs remain at reset values.
